// File: rtl/bus_pkg.sv
// Constants and helpers shared by the bus master and slave_receiver:
// the word width and the six-word cyclic test pattern.
package bus_pkg;

  localparam int          DW_DEFAULT = 24;
  localparam logic [23:0] PAT_BASE   = 24'h001122;
  localparam logic [23:0] PAT_STEP   = 24'h111111;
  localparam int          NUM_PAT    = 6;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } pat_lookup_t;

  function automatic logic [23:0] pat_word(input logic [2:0] idx);
    return PAT_BASE + (24'(idx) * PAT_STEP);
  endfunction

  function automatic logic [2:0] pat_next(input logic [2:0] idx);
    return (idx == 3'(NUM_PAT - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

  // Reverse lookup used to resynchronise the checker after a mismatch.
  function automatic pat_lookup_t pat_find(input logic [23:0] word);
    pat_lookup_t res;
    res.hit = 1'b0;
    res.idx = 3'd0;
    for (int k = 0; k < NUM_PAT; k++) begin
      if (word == pat_word(3'(k))) begin
        res.hit = 1'b1;
        res.idx = 3'(k);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an explicit occupancy count.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int DW    = 24,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DW-1:0]                wr_data,
  output logic [DW-1:0]                rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow is the mod-DEPTH wrap.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; empty/count decide whether a slot is meaningful.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/slave_receiver.sv
// Receiving end of the 24-bit word bus: buffers accepted words in a FIFO and
// checks each one against the master's six-word cyclic pattern.
module slave_receiver
  import bus_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          slave_en,
  input  logic          master_valid,
  output logic          bus_ready,
  input  logic [DW-1:0] master_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          seq_err,
  output logic [7:0]    err_cnt,
  output logic [15:0]   word_cnt
);

  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both 1. valid never waits on ready, and ready is never derived from valid.

  logic          accept, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_fifo_count;
  logic [23:0]   word24;
  pat_lookup_t   lookup;

  logic [2:0]  exp_idx_q, exp_idx_d;
  logic        seq_err_q, seq_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;

  assign bus_ready = slave_en && !fifo_full && !RST;
  assign accept    = master_valid && bus_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  assign seq_err  = seq_err_q;
  assign err_cnt  = err_cnt_q;
  assign word_cnt = word_cnt_q;

  assign unused_fifo_count = ^fifo_count;
  assign word24            = 24'(master_data);

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (RST),
    .push    (accept),
    .pop     (pop),
    .wr_data (master_data),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    exp_idx_d  = exp_idx_q;
    seq_err_d  = 1'b0;
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
    lookup     = pat_find(word24);
    if (accept) begin
      word_cnt_d = word_cnt_q + 16'd1;
      if (word24 == pat_word(exp_idx_q)) begin
        exp_idx_d = pat_next(exp_idx_q);
      end else begin
        seq_err_d = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        // Lock onto whatever pattern word was seen, or restart the cycle.
        exp_idx_d = lookup.hit ? pat_next(lookup.idx) : 3'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      exp_idx_q  <= 3'd0;
      seq_err_q  <= 1'b0;
      err_cnt_q  <= 8'd0;
      word_cnt_q <= 16'd0;
    end else begin
      exp_idx_q  <= exp_idx_d;
      seq_err_q  <= seq_err_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule
